// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding
// and the CTRL register bit layout.
package irq_ctrl_pkg;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int CTRL_GEN_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req (bit 0 wins)
// and whether any bit is set.
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int VW   = 2
) (
  input  logic [NSRC-1:0] req,
  output logic [VW-1:0]   idx,
  output logic            any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = {VW{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      idx = req[i] ? VW'(i) : idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge latching into PENDING, mask and global
// enable, fixed priority, and an irq/ack/eoi handshake towards the CPU.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int DW   = 16,
  parameter int VW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            wr,
  input  logic            rd,
  input  logic [1:0]      addr,
  input  logic [DW-1:0]   datain,
  output logic [DW-1:0]   dataout,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic [VW-1:0]   vector,
  input  logic            irq_ack,
  input  logic            eoi
);

  logic [NSRC-1:0] src_q_r;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] mask_r;
  logic            gen_r;
  state_t          state_r;
  logic            irq_r;
  logic [VW-1:0]   vector_r;
  logic [DW-1:0]   dataout_r;

  logic [NSRC-1:0] edge_s;
  logic [NSRC-1:0] w1c_s;
  logic [NSRC-1:0] ack_clr_s;
  logic [NSRC-1:0] pending_nxt_s;
  logic [NSRC-1:0] req_s;
  logic [VW-1:0]   win_idx_s;
  logic            win_any_s;
  logic            wr_en_s;
  logic            rd_en_s;
  logic            ack_s;
  logic            still_req_s;
  logic [DW-1:0]   rd_data_s;
  logic            unused_s;

  assign wr_en_s     = cs & wr;
  assign rd_en_s     = cs & rd;
  assign edge_s      = src & ~src_q_r;
  assign ack_s       = (state_r == REQ) & irq_ack;
  assign req_s       = gen_r ? (pending_r & mask_r) : {NSRC{1'b0}};
  assign still_req_s = pending_r[vector_r] & mask_r[vector_r] & gen_r;
  assign unused_s    = ^datain;

  irq_prio_enc #(
    .NSRC (NSRC),
    .VW   (VW)
  ) u_prio (
    .req (req_s),
    .idx (win_idx_s),
    .any (win_any_s)
  );

  // Write-1-to-clear mask from the bus.
  always_comb begin
    w1c_s = {NSRC{1'b0}};
    if (wr_en_s && (addr == ADDR_PEND)) begin
      w1c_s = datain[NSRC-1:0];
    end else begin
      w1c_s = {NSRC{1'b0}};
    end
  end

  // Clear of the serviced source when the CPU acknowledges.
  always_comb begin
    ack_clr_s = {NSRC{1'b0}};
    if (ack_s) begin
      ack_clr_s[vector_r] = 1'b1;
    end else begin
      ack_clr_s = {NSRC{1'b0}};
    end
  end

  // A new edge wins over a clear of the same bit in the same cycle.
  assign pending_nxt_s = (pending_r & ~(w1c_s | ack_clr_s)) | edge_s;

  // Read data mux; bits outside each field read as zero.
  always_comb begin
    rd_data_s = {DW{1'b0}};
    case (addr)
      ADDR_MASK: rd_data_s[NSRC-1:0]   = mask_r;
      ADDR_PEND: rd_data_s[NSRC-1:0]   = pending_r;
      ADDR_CTRL: rd_data_s[CTRL_GEN_BIT] = gen_r;
      ADDR_STAT: rd_data_s[VW+1:0]     = {state_r, vector_r};
      default:   rd_data_s = {DW{1'b0}};
    endcase
  end

  // Edge detector, pending, configuration registers and read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q_r   <= src;
      pending_r <= {NSRC{1'b0}};
      mask_r    <= {NSRC{1'b0}};
      gen_r     <= 1'b0;
      dataout_r <= {DW{1'b0}};
    end else begin
      src_q_r   <= src;
      pending_r <= pending_nxt_s;
      if (wr_en_s && (addr == ADDR_MASK)) begin
        mask_r <= datain[NSRC-1:0];
      end else begin
        mask_r <= mask_r;
      end
      if (wr_en_s && (addr == ADDR_CTRL)) begin
        gen_r <= datain[CTRL_GEN_BIT];
      end else begin
        gen_r <= gen_r;
      end
      if (rd_en_s) begin
        dataout_r <= rd_data_s;
      end else begin
        dataout_r <= dataout_r;
      end
    end
  end

  // CPU handshake FSM; vector is frozen from grant until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      irq_r    <= 1'b0;
      vector_r <= {VW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (win_any_s) begin
            state_r  <= REQ;
            irq_r    <= 1'b1;
            vector_r <= win_idx_s;
          end else begin
            state_r  <= IDLE;
            irq_r    <= 1'b0;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_r <= SVC;
            irq_r   <= 1'b0;
          end else if (!still_req_s) begin
            state_r <= IDLE;
            irq_r   <= 1'b0;
          end else begin
            state_r <= REQ;
            irq_r   <= 1'b1;
          end
        end
        SVC: begin
          irq_r <= 1'b0;
          if (eoi) begin
            state_r <= IDLE;
          end else begin
            state_r <= SVC;
          end
        end
        default: begin
          state_r <= IDLE;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

  assign dataout = dataout_r;
  assign irq     = irq_r;
  assign vector  = vector_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: scenario tasks with a queue of expected
// register read values that is drained as each read returns.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NSRC = 4;
  localparam int DW   = 16;
  localparam int VW   = 2;

  logic            clk;
  logic            rst_n;
  logic            cs;
  logic            wr;
  logic            rd;
  logic [1:0]      addr;
  logic [DW-1:0]   datain;
  logic [DW-1:0]   dataout;
  logic [NSRC-1:0] src;
  logic            irq;
  logic [VW-1:0]   vector;
  logic            irq_ack;
  logic            eoi;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  irq_ctrl #(.NSRC(NSRC), .DW(DW), .VW(VW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .src     (src),
    .irq     (irq),
    .vector  (vector),
    .irq_ack (irq_ack),
    .eoi     (eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; datain = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; datain = '0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = dataout;
  endtask

  task automatic pulse_ack();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    @(negedge clk); eoi = 1'b1;
    @(negedge clk); eoi = 1'b0;
  endtask

  // Read a register and compare against the oldest queued expectation.
  task automatic read_cmp(input logic [1:0] a, input string name);
    logic [DW-1:0] got;
    logic [DW-1:0] e;
    do_read(a, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, e);
    end
  endtask

  task automatic test_reset();
    src = 4'b0001;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (irq !== 1'b0 || dataout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got irq=%b dataout=%h expected irq=0 dataout=0000", irq, dataout);
    end
    do_write(ADDR_MASK, 16'h000F);
    do_write(ADDR_CTRL, 16'h0001);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL held_src_no_irq: got irq=%b expected 0", irq);
    end
    exp_q.push_back(16'h0000);
    read_cmp(ADDR_PEND, "held_src_pending");
    exp_q.push_back(16'h000F);
    read_cmp(ADDR_MASK, "mask_readback");
  endtask

  task automatic test_latency();
    src = 4'b0000;
    @(negedge clk);
    src = 4'b0001;
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL latency_k: got irq=%b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1 || vector !== 2'd0) begin
      errors++;
      $display("FAIL latency_k1: got irq=%b vector=%0d expected irq=1 vector=0", irq, vector);
    end
    exp_q.push_back(16'h0001);
    read_cmp(ADDR_PEND, "pending_src0");
    pulse_ack();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL ack_drops_irq: got irq=%b expected 0", irq);
    end
    exp_q.push_back(16'h0008);
    read_cmp(ADDR_STAT, "status_svc");
    pulse_eoi();
    exp_q.push_back(16'h0000);
    read_cmp(ADDR_STAT, "status_idle");
  endtask

  task automatic test_priority();
    @(negedge clk);
    src = 4'b0111;
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1 || vector !== 2'd1) begin
      errors++;
      $display("FAIL prio_vec1: got irq=%b vector=%0d expected irq=1 vector=1", irq, vector);
    end
    pulse_ack();
    exp_q.push_back(16'h0004);
    read_cmp(ADDR_PEND, "pending_after_ack");
    pulse_eoi();
    @(negedge clk);
    checks++;
    if (irq !== 1'b1 || vector !== 2'd2) begin
      errors++;
      $display("FAIL after_eoi_vec2: got irq=%b vector=%0d expected irq=1 vector=2", irq, vector);
    end
    pulse_ack();
    pulse_eoi();
    src = 4'b0000;
  endtask

  task automatic test_mask();
    do_write(ADDR_MASK, 16'h000E);
    @(negedge clk);
    src = 4'b0001;
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_no_irq: got irq=%b expected 0", irq);
    end
    exp_q.push_back(16'h0001);
    read_cmp(ADDR_PEND, "masked_pending");
    do_write(ADDR_MASK, 16'h000F);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1 || vector !== 2'd0) begin
      errors++;
      $display("FAIL unmask_irq: got irq=%b vector=%0d expected irq=1 vector=0", irq, vector);
    end
    pulse_ack();
    pulse_eoi();
    src = 4'b0000;
  endtask

  task automatic test_withdraw();
    @(negedge clk);
    src = 4'b1000;
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1 || vector !== 2'd3) begin
      errors++;
      $display("FAIL vec3_req: got irq=%b vector=%0d expected irq=1 vector=3", irq, vector);
    end
    do_write(ADDR_PEND, 16'h0008);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_irq: got irq=%b expected 0", irq);
    end
    exp_q.push_back(16'h0003);
    read_cmp(ADDR_STAT, "withdraw_status");
  endtask

  task automatic test_set_priority();
    do_write(ADDR_CTRL, 16'h0000);
    @(negedge clk);
    src = 4'b1010;
    @(negedge clk);
    src = 4'b1000;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = ADDR_PEND; datain = 16'h0002;
    src = 4'b1010;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; datain = '0;
    exp_q.push_back(16'h0002);
    read_cmp(ADDR_PEND, "edge_beats_w1c");
    do_write(ADDR_PEND, 16'h0002);
    exp_q.push_back(16'h0000);
    read_cmp(ADDR_PEND, "plain_w1c");
    do_write(ADDR_CTRL, 16'h0001);
    exp_q.push_back(16'h0001);
    read_cmp(ADDR_CTRL, "ctrl_readback");
  endtask

  task automatic test_reset_in_svc();
    @(negedge clk);
    src = 4'b0000;
    @(negedge clk);
    src = 4'b0100;
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1 || vector !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_req: got irq=%b vector=%0d expected irq=1 vector=2", irq, vector);
    end
    pulse_ack();
    exp_q.push_back(16'h000A);
    read_cmp(ADDR_STAT, "status_svc_vec2");
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if (irq !== 1'b0 || dataout !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_outputs: got irq=%b dataout=%h expected irq=0 dataout=0000", irq, dataout);
    end
    exp_q.push_back(16'h0000);
    read_cmp(ADDR_STAT, "status_after_reset");
    pulse_eoi();
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL eoi_after_reset: got irq=%b expected 0", irq);
    end
    exp_q.push_back(16'h0000);
    read_cmp(ADDR_STAT, "status_after_eoi");
    exp_q.push_back(16'h0000);
    read_cmp(ADDR_MASK, "mask_after_reset");
  endtask

  initial begin
    cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; datain = '0;
    irq_ack = 1'b0; eoi = 1'b0; src = '0; rst_n = 1'b0;
    test_reset();
    test_latency();
    test_priority();
    test_mask();
    test_withdraw();
    test_set_priority();
    test_reset_in_svc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
